transmisor_tx: RTL and testbench



---
 rtl/transmisor_tx.sv | 164 ++++++++++++++++
 tb/tb_transmisor_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/transmisor_tx.sv
// UART 8N1 transmitter with a one-entry holding buffer, paced by a 16x baud tick.
// Optional even-parity bit between data and stop when TX_PARITY_EN is defined.
module transmisor_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int OS_TICK = 16
) (
    input  logic       MCLK,
    input  logic       RST,
    input  logic       tick_clk,
    input  logic [7:0] DATAIN,
    input  logic       TX_Start,
    output logic       TX,
    output logic       TX_Done,
    output logic       Buffer_Full
);

    localparam int SMAX = (OS_TICK > SB_TICK) ? OS_TICK : SB_TICK;
    localparam int SW   = (SMAX > 2) ? $clog2(SMAX) : 1;

    localparam logic [SW-1:0] S_BIT_LAST  = SW'(OS_TICK - 1);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [2:0]    N_LAST      = 3'(DBIT - 1);

`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state, state_next;
    logic [SW-1:0]   s, s_next;
    logic [2:0]      n, n_next;
    logic [7:0]      shift, shift_next;
    logic [7:0]      hold;
    logic            drain;
    logic            tx_next;
    logic            done_next;
`ifdef TX_PARITY_EN
    logic            parity;
`endif

    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            s       <= '0;
            n       <= '0;
            shift   <= '0;
            TX      <= 1'b1;
            TX_Done <= 1'b0;
        end else begin
            state   <= state_next;
            s       <= s_next;
            n       <= n_next;
            shift   <= shift_next;
            TX      <= tx_next;
            TX_Done <= done_next;
        end
    end

    // Drain and write are exclusive: drain needs Buffer_Full=1, write needs 0.
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            hold        <= '0;
            Buffer_Full <= 1'b0;
        end else if (drain) begin
            Buffer_Full <= 1'b0;
        end else if (TX_Start && !Buffer_Full) begin
            hold        <= DATAIN;
            Buffer_Full <= 1'b1;
        end
    end

`ifdef TX_PARITY_EN
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            parity <= 1'b0;
        end else if (drain) begin
            parity <= ^hold[DBIT-1:0];
        end
    end
`endif

    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        shift_next = shift;
        drain      = 1'b0;
        done_next  = 1'b0;
        tx_next    = 1'b1;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (Buffer_Full) begin
                    drain      = 1'b1;
                    shift_next = hold;
                    s_next     = '0;
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (tick_clk) begin
                    if (s == S_BIT_LAST) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = DATA;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            DATA: begin
                tx_next = shift[0];
                if (tick_clk) begin
                    if (s == S_BIT_LAST) begin
                        s_next     = '0;
                        shift_next = {1'b0, shift[7:1]};
                        if (n == N_LAST) begin
`ifdef TX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_next = n + 1'b1;
                        end
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                tx_next = parity;
                if (tick_clk) begin
                    if (s == S_BIT_LAST) begin
                        s_next     = '0;
                        state_next = STOP;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                tx_next = 1'b1;
                if (tick_clk) begin
                    if (s == S_STOP_LAST) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_transmisor_tx.sv
// Bench for transmisor_tx: a serial-line receiver decodes frames and checks them
// against a queue of expected frames pushed when each byte is written.
module tb_transmisor_tx;

`ifdef TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       mclk;
    logic       rst;
    logic       tick_clk;
    logic [7:0] datain;
    logic       tx_start;
    logic       tx;
    logic       tx_done;
    logic       buffer_full;

    transmisor_tx #(.DBIT(8), .SB_TICK(16), .OS_TICK(16)) dut (
        .MCLK        (mclk),
        .RST         (rst),
        .tick_clk    (tick_clk),
        .DATAIN      (datain),
        .TX_Start    (tx_start),
        .TX          (tx),
        .TX_Done     (tx_done),
        .Buffer_Full (buffer_full)
    );

    int unsigned nvec = 0;
    int unsigned nerr = 0;
    int unsigned done_cnt = 0;
    logic        tick_en = 1'b1;
    logic [10:0] expq[$];

    typedef struct {
        logic [7:0] d;
        logic       p;
    } vec_t;
    vec_t vecs[7];

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    // One-cycle tick every 4 MCLK while enabled; phase restarts on re-enable.
    initial begin
        int unsigned phase;
        phase    = 0;
        tick_clk = 1'b0;
        forever begin
            @(posedge mclk);
            #1;
            if (tick_en) begin
                phase    = (phase + 1) % 4;
                tick_clk = (phase == 0);
            end else begin
                phase    = 0;
                tick_clk = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge mclk);
            #1;
            if (tx_done) done_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic p);
        logic [10:0] f;
        f      = '0;
        f[8:1] = d;
        f[9]   = (NB == 11) ? p : 1'b1;
        f[10]  = (NB == 11);
        return f;
    endfunction

    task automatic cyc(input int unsigned k);
        repeat (k) @(posedge mclk);
        #1;
    endtask

    task automatic write(input logic [7:0] d, input logic p, input bit push);
        tx_start = 1'b1;
        datain   = d;
        cyc(1);
        tx_start = 1'b0;
        if (push) expq.push_back(frame(d, p));
    endtask

    // Samples mid-bit: start at +32 cycles after the fall, then every 64 cycles.
    task automatic recv(input bit skip_start, input int unsigned max_wait);
        logic [10:0] got;
        logic [10:0] want;
        int unsigned w;
        got = '0;
        if (!skip_start) begin
            w = 0;
            while (tx !== 1'b0 && w < max_wait) begin
                cyc(1);
                w++;
            end
            if (tx !== 1'b0) begin
                chk("start_timeout", {31'd0, tx}, 32'd0);
                return;
            end
        end
        cyc(32);
        got[0] = tx;
        for (int i = 1; i < NB; i++) begin
            cyc(64);
            got[i] = tx;
        end
        if (expq.size() == 0) begin
            chk("unexpected_frame", {21'd0, got}, 32'd0);
        end else begin
            want = expq.pop_front();
            chk("frame_bits", {21'd0, got}, {21'd0, want});
        end
        w = 0;
        while (tx_done !== 1'b1 && w < 48) begin
            cyc(1);
            w++;
        end
        chk("done_seen", {31'd0, tx_done}, 32'd1);
        cyc(1);
        chk("done_width", {31'd0, tx_done}, 32'd0);
    endtask

    initial begin
        int unsigned d0;
        int unsigned w;
        bit          line_ok;

        vecs[0] = '{8'h55, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h03, 1'b0};
        vecs[3] = '{8'h01, 1'b1};
        vecs[4] = '{8'h80, 1'b1};
        vecs[5] = '{8'h00, 1'b0};
        vecs[6] = '{8'hFF, 1'b0};

        rst      = 1'b1;
        tx_start = 1'b0;
        datain   = '0;
        cyc(3);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_done", {31'd0, tx_done}, 32'd0);
        chk("rst_bf", {31'd0, buffer_full}, 32'd0);
        rst = 1'b0;
        cyc(5);
        chk("idle_tx", {31'd0, tx}, 32'd1);

        for (int i = 0; i < 7; i++) begin
            d0 = done_cnt;
            fork
                recv(1'b0, 200);
                begin
                    write(vecs[i].d, vecs[i].p, 1'b1);
                    chk("write_bf", {31'd0, buffer_full}, 32'd1);
                end
            join
            cyc(2);
            chk("single_done_cnt", done_cnt - d0, 32'd1);
        end

        // Back-to-back frames with an overflow attempt while the buffer is full.
        d0 = done_cnt;
        fork
            begin
                recv(1'b0, 200);
                recv(1'b0, 8);
            end
            begin
                write(8'hA3, 1'b0, 1'b1);
                w = 0;
                while (buffer_full && w < 10) begin
                    cyc(1);
                    w++;
                end
                chk("drain_bf", {31'd0, buffer_full}, 32'd0);
                write(8'h0F, 1'b0, 1'b1);
                chk("second_bf", {31'd0, buffer_full}, 32'd1);
                write(8'hFF, 1'b0, 1'b0);
                chk("overflow_bf", {31'd0, buffer_full}, 32'd1);
            end
        join
        cyc(300);
        chk("b2b_done_cnt", done_cnt - d0, 32'd2);
        chk("b2b_line_idle", {31'd0, tx}, 32'd1);

        // No ticks: frame parks in START, then completes once ticks resume.
        tick_en = 1'b0;
        cyc(2);
        write(8'h81, 1'b0, 1'b1);
        cyc(100);
        chk("park_tx", {31'd0, tx}, 32'd0);
        chk("park_bf", {31'd0, buffer_full}, 32'd0);
        d0 = done_cnt;
        tick_en = 1'b1;
        recv(1'b1, 0);
        chk("park_done_cnt", done_cnt - d0, 32'd1);

        // Reset in the middle of data bit 3 with a byte also buffered.
        cyc(20);
        write(8'h55, 1'b0, 1'b0);
        w = 0;
        while (tx !== 1'b0 && w < 200) begin
            cyc(1);
            w++;
        end
        chk("mid_start", {31'd0, tx}, 32'd0);
        cyc(32 + 64 * 4);
        write(8'h0F, 1'b0, 1'b0);
        chk("mid_bf", {31'd0, buffer_full}, 32'd1);
        chk("mid_bit3", {31'd0, tx}, 32'd0);
        @(posedge mclk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_tx", {31'd0, tx}, 32'd1);
        chk("async_rst_bf", {31'd0, buffer_full}, 32'd0);
        d0 = done_cnt;
        cyc(3);
        rst = 1'b0;
        line_ok = 1'b1;
        for (int i = 0; i < 400; i++) begin
            cyc(1);
            if (tx !== 1'b1) line_ok = 1'b0;
        end
        chk("post_rst_idle", {31'd0, line_ok}, 32'd1);
        chk("post_rst_no_done", done_cnt - d0, 32'd0);

        fork
            recv(1'b0, 200);
            write(8'h5A, 1'b0, 1'b1);
        join
        chk("queue_empty", expq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
